cpu_trace_tx: RTL and testbench
===============================

// Module: cpu_trace_tx
// PURPOSE
//  Trace transmitter for the single-cycle CPU. On each retired instruction it captures pc and
//  inst, freezes the CPU via halt, and streams one frame (sync, seq, pc, inst, all GPRs) as
//  bytes over a valid/ready port. It is the producer for the per-cycle pc/instr/regfile dump.
//  Sits inside sccomp_dataflow, beside the CPU, the IMEM and the regfile.
// PARAMETERS
//  NUM_REGS   32      GPRs sent per frame (indices 0..NUM_REGS-1)
//  SYNC_BYTE  8'hA5   first byte of every frame
// PORTS
//  clk_in     in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  retire     in   1   one instruction retired this cycle (pc/inst valid)
//  pc         in   32  pc of the retiring instruction
//  inst       in   32  retiring instruction word
//  rf_addr    out  5   regfile read address (combinational-read regfile)
//  rf_rdata   in   32  regfile data for rf_addr, same cycle
//  halt       out  1   CPU clock-enable freeze; 1 while a frame is in flight
//  tx_data    out  8   stream byte
//  tx_valid   out  1   tx_data valid
//  tx_ready   in   1   sink accepts; a transfer occurs on tx_valid & tx_ready
//  drop_cnt   out  8   retires ignored while busy; saturates at 255
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, tx_valid=0, tx_data=0, halt=0, rf_addr=0, seq=0, drop_cnt=0.
//   Any partial frame is abandoned and never resumed.
//  Frame: SYNC_BYTE, seq, pc[31:24..7:0], inst[31:24..7:0], r0..r(NUM_REGS-1), each word big-endian.
//   Length = 10+4*NUM_REGS bytes (138 by default).
//  FSM: IDLE -> HDR -> SEQ -> PC -> INST -> REGS -> IDLE. A 2-bit byte counter is used in PC/INST/REGS.
//   A 5-bit register index is used in REGS.
//  A state advances only on a transfer. HDR/SEQ take 1 transfer each. PC/INST take 4 transfers each.
//   REGS takes 4*NUM_REGS transfers.
//  Capture: retire=1 in IDLE, sampled at edge N. At that edge pc and inst are latched, halt<=1,
//   tx_valid<=1, tx_data<=SYNC_BYTE and rf_addr<=0. Latency: first byte is valid 1 cycle after retire.
//  Data path: a 32-bit word register with tx_data = word[31:24]. Each transfer shifts the word left
//   by 8. The transfer of byte 3 of a word loads the next word: inst, then rf_rdata for rf_addr.
//   rf_addr increments after each regfile load.
//  rf_rdata is sampled only at load edges. The CPU is halted, so register contents are frame-stable.
//  Handshake: while tx_valid=1 and tx_ready=0, tx_data is held unchanged. tx_valid never drops
//   mid-frame. A transfer every cycle is supported (no bubbles).
//  End: the edge of the last transfer sets tx_valid<=0, halt<=0, state<=IDLE and seq<=seq+1.
//   seq is 8 bits and wraps 255->0. A frame carries the pre-increment seq, so the first frame is 0x00.
//  retire=1 in any state other than IDLE (including the final-transfer cycle) is ignored.
//   It increments drop_cnt, saturating at 255. pc/inst captured for the current frame are unaffected.
//  A retire in the cycle after the final transfer (halt=0, IDLE) starts a new frame normally.
//  tx_ready is ignored while tx_valid=0.
// TESTING
//  1. Reset; set r[k]=k*32'h01010101, then retire with pc=32'h00400000, inst=32'h3C011001, tx_ready=1.
//     Expect: 138 bytes A5 00 00 40 00 00 3C 01 10 01 00 00 00 00 01 01 01 01 ... 1F 1F 1F 1F.
//     Expect: halt=1 for exactly 138 cycles, tx_valid rising 1 cycle after retire.
//  2. Same as 1 with tx_ready alternating 1,0. Expect: identical bytes in 276 cycles.
//     Expect: tx_data stable during every valid&!ready cycle.
//  3. Retire pulsed 3 times mid-frame. Expect: drop_cnt=3 and frame bytes unchanged.
//     Then 300 mid-frame retires. Expect: drop_cnt=255 (saturates).
//  4. 257 back-to-back frames. Expect: seq byte 0xFF in frame 255 and 0x00 in frame 256.
//  5. Assert reset at byte 50 of a frame. Expect: tx_valid/halt=0 immediately, without a clock edge.
//     A later retire emits a full fresh frame with seq 0x00.
//  6. Retire coincident with the final transfer. Expect: drop_cnt+1 and no new frame.
//     Retire on the next cycle. Expect: a new frame with tx_valid=1 one cycle later.

Source files
------------

// File: rtl/cpu_trace_tx_if.sv
// Byte-stream port between the trace transmitter and its sink.
// master drives tx_data/tx_valid and samples tx_ready; slave is the mirror.
interface cpu_trace_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/cpu_trace_tx.sv
// Trace transmitter: on a retire it freezes the CPU and streams one frame
// (sync, seq, pc, inst, r0..rN-1, words big-endian) over a valid/ready byte port.
// Ports: clk_in, reset (async, active-high); retire/pc/inst from the CPU;
// rf_addr/rf_rdata to a combinational-read regfile; halt freezes the CPU;
// tx (master) carries the byte stream; drop_cnt counts retires ignored while busy.
module cpu_trace_tx #(
   parameter int         NUM_REGS  = 32,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        retire,
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_rdata,
   output logic        halt,
   cpu_trace_tx_if.master tx,
   output logic [7:0]  drop_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_SEQ,
      S_PC,
      S_INST,
      S_REGS
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_word;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [1:0]  r_byte;
   logic [4:0]  r_idx;
   logic [4:0]  r_addr;
   logic [7:0]  r_seq;
   logic [7:0]  r_drop;

   logic w_xfer;
   logic w_wlast;
   logic w_rlast;
   logic w_start;
   logic w_ld_seq;
   logic w_ld_pc;
   logic w_ld_inst;
   logic w_ld_rf;
   logic w_shift;
   logic w_done;

   // Valid and halt are both "a frame is in flight", so an async reset
   // to IDLE clears them immediately.
   assign tx.tx_valid = (r_state != S_IDLE);
   assign halt        = (r_state != S_IDLE);
   assign tx.tx_data  = r_word[31:24];
   assign rf_addr     = r_addr;
   assign drop_cnt    = r_drop;

   assign w_xfer  = tx.tx_valid & tx.tx_ready;
   assign w_wlast = (r_byte == 2'd3);
   assign w_rlast = (r_idx == 5'(NUM_REGS - 1));
   assign w_start = retire & (r_state == S_IDLE);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_ld_seq  = 1'b0;
      w_ld_pc   = 1'b0;
      w_ld_inst = 1'b0;
      w_ld_rf   = 1'b0;
      w_shift   = 1'b0;
      w_done    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (retire) begin
               w_next = S_HDR;
            end
         end
         S_HDR: begin
            if (w_xfer) begin
               w_next   = S_SEQ;
               w_ld_seq = 1'b1;
            end
         end
         S_SEQ: begin
            if (w_xfer) begin
               w_next  = S_PC;
               w_ld_pc = 1'b1;
            end
         end
         S_PC: begin
            if (w_xfer) begin
               if (w_wlast) begin
                  w_next    = S_INST;
                  w_ld_inst = 1'b1;
               end else begin
                  w_shift = 1'b1;
               end
            end
         end
         S_INST: begin
            if (w_xfer) begin
               if (w_wlast) begin
                  w_next  = S_REGS;
                  w_ld_rf = 1'b1;
               end else begin
                  w_shift = 1'b1;
               end
            end
         end
         S_REGS: begin
            if (w_xfer) begin
               if (w_wlast && w_rlast) begin
                  w_next = S_IDLE;
                  w_done = 1'b1;
               end else if (w_wlast) begin
                  w_ld_rf = 1'b1;
               end else begin
                  w_shift = 1'b1;
               end
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_word <= 32'h0;
         r_pc   <= 32'h0;
         r_inst <= 32'h0;
         r_byte <= 2'd0;
         r_idx  <= 5'd0;
         r_addr <= 5'd0;
         r_seq  <= 8'h00;
      end else begin
         if (w_start) begin
            r_pc   <= pc;
            r_inst <= inst;
            r_word <= {SYNC_BYTE, 24'h0};
            r_byte <= 2'd0;
            r_idx  <= 5'd0;
            r_addr <= 5'd0;
         end
         if (w_ld_seq) begin
            r_word <= {r_seq, 24'h0};
         end
         if (w_ld_pc) begin
            r_word <= r_pc;
            r_byte <= 2'd0;
         end
         if (w_shift) begin
            r_word <= {r_word[23:0], 8'h00};
            r_byte <= r_byte + 2'd1;
         end
         if (w_ld_inst) begin
            r_word <= r_inst;
            r_byte <= 2'd0;
         end
         // rf_addr already points at the next register to send; the
         // word index only advances for loads made inside REGS.
         if (w_ld_rf) begin
            r_word <= rf_rdata;
            r_byte <= 2'd0;
            r_addr <= r_addr + 5'd1;
            if (r_state == S_REGS) begin
               r_idx <= r_idx + 5'd1;
            end
         end
         if (w_done) begin
            r_word <= 32'h0;
            r_byte <= 2'd0;
            r_idx  <= 5'd0;
            r_addr <= 5'd0;
            r_seq  <= r_seq + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_drop <= 8'h00;
      end else if (retire && (r_state != S_IDLE) && (r_drop != 8'hFF)) begin
         r_drop <= r_drop + 8'd1;
      end
   end

endmodule

// File: tb/tb_cpu_trace_tx.sv
// Scoreboard bench for cpu_trace_tx: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares every accepted byte.
module tb_cpu_trace_tx;

   logic        clk;
   logic        reset;
   logic        retire;
   logic [31:0] i_pc;
   logic [31:0] i_inst;
   logic [4:0]  rf_addr;
   logic [31:0] rf_rdata;
   logic        halt;
   logic [7:0]  drop_cnt;
   logic [31:0] regs [32];

   cpu_trace_tx_if txi ();

   cpu_trace_tx dut (
      .clk_in   (clk),
      .reset    (reset),
      .retire   (retire),
      .pc       (i_pc),
      .inst     (i_inst),
      .rf_addr  (rf_addr),
      .rf_rdata (rf_rdata),
      .halt     (halt),
      .tx       (txi),
      .drop_cnt (drop_cnt)
   );

   assign rf_rdata = regs[rf_addr];

   int          n_pass  = 0;
   int          n_total = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  exp_seq  = 8'h00;
   int          exp_drop = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic push_frame(input logic [7:0] s, input logic [31:0] p,
                             input logic [31:0] ins);
      exp_q.push_back(8'hA5);
      exp_q.push_back(s);
      push_word(p);
      push_word(ins);
      for (int k = 0; k < 32; k++) begin
         push_word(32'(k) * 32'h01010101);
      end
   endtask

   // Monitor: a byte is accepted at the posedge following a negedge that
   // sees valid&ready; also checks data holds across stalled cycles.
   initial begin
      logic       held;
      logic [7:0] held_data;
      held = 1'b0;
      held_data = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            held = 1'b0;
         end else begin
            if (held && txi.tx_valid) begin
               chk("hold_data", 32'(txi.tx_data), 32'(held_data));
            end
            held = txi.tx_valid && !txi.tx_ready;
            held_data = txi.tx_data;
            if (txi.tx_valid && txi.tx_ready) begin
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL extra_byte: got %h expected none", txi.tx_data);
               end else begin
                  chk("byte", 32'(txi.tx_data), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   // Called at posedge+1 with the DUT idle. Retire is raised this cycle.
   task automatic run_frame(input logic [31:0] p, input logic [31:0] ins,
                            input bit alt, input int stall,
                            input int drop_start, input int n_drops,
                            input int abort_at, input int exp_cycles);
      int cycles;
      bit aborted;
      chk("idle_valid", 32'(txi.tx_valid), 32'd0);
      push_frame(exp_seq, p, ins);
      i_pc = p;
      i_inst = ins;
      retire = 1'b1;
      @(posedge clk);
      #1;
      retire = 1'b0;
      i_pc = 32'hDEADBEEF;
      i_inst = 32'hBAADF00D;
      chk("latency_valid", 32'(txi.tx_valid), 32'd1);
      chk("latency_halt", 32'(halt), 32'd1);
      cycles = 0;
      aborted = 1'b0;
      while (halt && cycles < 3000) begin
         cycles++;
         if (abort_at != 0 && cycles == abort_at) begin
            reset = 1'b1;
            #1;
            chk("async_rst_valid", 32'(txi.tx_valid), 32'd0);
            chk("async_rst_halt", 32'(halt), 32'd0);
            exp_q.delete();
            exp_seq = 8'h00;
            exp_drop = 0;
            aborted = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            break;
         end
         if (alt) begin
            txi.tx_ready = ~cycles[0];
         end else begin
            txi.tx_ready = !(cycles >= 2 && cycles < 2 + stall);
         end
         retire = (cycles >= drop_start) && (cycles < drop_start + n_drops);
         if (retire && exp_drop < 255) begin
            exp_drop++;
         end
         @(posedge clk);
         #1;
      end
      retire = 1'b0;
      txi.tx_ready = 1'b1;
      if (!aborted) begin
         chk("halt_cycles", 32'(cycles), 32'(exp_cycles));
         chk("frame_done", 32'(exp_q.size()), 32'd0);
         chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
         exp_seq = exp_seq + 8'd1;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 32; k++) begin
         regs[k] = 32'(k) * 32'h01010101;
      end
      reset = 1'b1;
      retire = 1'b0;
      i_pc = 32'h0;
      i_inst = 32'h0;
      txi.tx_ready = 1'b1;
      #1;
      chk("rst_valid", 32'(txi.tx_valid), 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_data", 32'(txi.tx_data), 32'd0);
      chk("rst_addr", 32'(rf_addr), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // basic frame, full-rate sink
      run_frame(32'h00400000, 32'h3C011001, 1'b0, 0, 0, 0, 0, 138);
      // alternating ready starting low
      run_frame(32'h00400004, 32'h8C220004, 1'b1, 0, 0, 0, 0, 276);
      // three mid-frame retires
      run_frame(32'h00400008, 32'h00221820, 1'b0, 0, 10, 3, 0, 138);
      // 300 retires during a long stall: saturates at 255
      run_frame(32'h0040000C, 32'hAC030008, 1'b0, 350, 2, 300, 0, 488);
      chk("drop_sat", 32'(drop_cnt), 32'd255);

      // reset at byte 50, then a fresh frame starts at seq 0
      run_frame(32'h00400010, 32'h1000FFFF, 1'b0, 0, 0, 0, 50, 0);
      chk("post_rst_drop", 32'(drop_cnt), 32'd0);
      run_frame(32'h00400014, 32'h24420001, 1'b0, 0, 0, 0, 0, 138);

      // retire on the final transfer is dropped and starts nothing
      run_frame(32'h00400018, 32'h08100000, 1'b0, 0, 138, 1, 0, 138);
      chk("final_drop", 32'(drop_cnt), 32'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("no_new_frame", 32'(txi.tx_valid), 32'd0);
      end
      // retire in the cycle right after the final transfer
      run_frame(32'h0040001C, 32'h03E00008, 1'b0, 0, 0, 0, 0, 138);
      run_frame(32'h00400020, 32'h00000000, 1'b0, 0, 0, 0, 0, 138);

      // 257 back-to-back frames from reset: seq FF then wraps to 00
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_seq = 8'h00;
      exp_drop = 0;
      exp_q.delete();
      for (int f = 0; f < 257; f++) begin
         run_frame(32'h00400000 + 32'(f * 4), 32'h20000000 + 32'(f), 1'b0,
                   0, 0, 0, 0, 138);
      end
      chk("seq_wrap", 32'(exp_seq), 32'h01);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
